// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with mid-bit sampling, valid and frame-error
//            strobes. Optional 2-of-3 majority sampling via UART_RX_MAJORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int MID          = CLKS_PER_BIT / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int SKEW         = 1;
`else
    localparam int SKEW         = 0;
`endif
    localparam logic [CW-1:0] START_PT = CW'(MID + SKEW);
    localparam logic [CW-1:0] BIT_PT   = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic          sync1_q, sync2_q, rx_prev_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    logic          w_rx_s;
    logic [CW-1:0] w_pt;
    logic          w_at_pt;
    logic          w_bit;

    assign w_rx_s  = sync2_q;
    // Start bit is sampled half a bit in; later bits are a full bit apart.
    assign w_pt    = (state_q == S_START) ? START_PT : BIT_PT;
    assign w_at_pt = (cnt_q == w_pt);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (cnt_q == w_pt - CW'(2)) vote_d[0] = w_rx_s;
        if (cnt_q == w_pt - CW'(1)) vote_d[1] = w_rx_s;
    end

    assign w_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & w_rx_s) | (vote_q[1] & w_rx_s);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vote_q <= 2'b11;
        else        vote_q <= vote_d;
    end
`else
    assign w_bit = w_rx_s;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !w_rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (w_at_pt) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = w_bit ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (w_at_pt) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = w_bit;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (w_at_pt) begin
                    cnt_d = '0;
                    if (w_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
